// File: rtl/fifo_read_streamer.sv
// Read-domain drain engine: pops the dual-clock FIFO into a 2-entry skid buffer and
// presents a registered valid/ready stream framed into fixed-length bursts.
module fifo_read_streamer #(
  parameter int data_size    = 8,
  parameter int burst_length = 16,
  parameter int count_size   = 16
) (
  input  logic                  read_clk,
  input  logic                  rreset,
  input  logic                  read_enable,
  input  logic                  read_empty,
  input  logic [data_size-1:0]  read_data,
  output logic                  read_incr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_size-1:0]  out_data,
  output logic                  out_last,
  output logic [count_size-1:0] words_read
);

  localparam int BEAT_W = (burst_length > 1) ? $clog2(burst_length) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_length - 1);

  logic [1:0]            buf_count_p0;
  logic [data_size-1:0]  head_p0;
  logic [data_size-1:0]  tail_p0;
  logic [BEAT_W-1:0]     beat_p0;
  logic [count_size-1:0] words_p0;
  logic                  push;
  logic                  pop;

  function automatic logic [count_size-1:0] sat_inc(input logic [count_size-1:0] value);
    return (value == {count_size{1'b1}}) ? value : value + 1'b1;
  endfunction

  function automatic logic [BEAT_W-1:0] beat_next(input logic [BEAT_W-1:0] value);
    return (value == LAST_BEAT) ? '0 : value + 1'b1;
  endfunction

  // A full buffer refuses the FIFO even when the consumer is ready this cycle, so
  // out_ready never reaches read_incr combinationally. Reset gates popping outright.
  assign push      = read_enable && !read_empty && (buf_count_p0 != 2'd2) && !rreset;
  assign pop       = out_valid && out_ready;
  assign read_incr = push;
  assign out_valid = (buf_count_p0 != 2'd0);
  assign out_data  = head_p0;
  assign out_last  = out_valid && (beat_p0 == LAST_BEAT);
  assign words_read = words_p0;

  // Stage p0: skid buffer; the head register drives the stream directly.
  always_ff @(posedge read_clk or posedge rreset) begin
    if (rreset) begin
      buf_count_p0 <= 2'd0;
      head_p0      <= '0;
      tail_p0      <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_count_p0 == 2'd0) head_p0 <= read_data;
          else                      tail_p0 <= read_data;
          buf_count_p0 <= buf_count_p0 + 2'd1;
        end
        2'b01: begin
          head_p0      <= tail_p0;
          buf_count_p0 <= buf_count_p0 - 2'd1;
        end
        2'b11: begin
          if (buf_count_p0 == 2'd1) begin
            head_p0 <= read_data;
          end else begin
            head_p0 <= tail_p0;
            tail_p0 <= read_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Burst position only advances on accepted beats, so FIFO gaps never shorten a burst.
  always_ff @(posedge read_clk or posedge rreset) begin
    if (rreset) begin
      beat_p0  <= '0;
      words_p0 <= '0;
    end else begin
      if (pop)  beat_p0  <= beat_next(beat_p0);
      if (push) words_p0 <= sat_inc(words_p0);
    end
  end

endmodule
